// File: rtl/uart_echo_responder.sv
// Echoes bytes received from the uart back through its transmitter, with a FIFO
// absorbing RX bursts and optional CR->CRLF expansion on the way out.
module uart_echo_responder #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8192,
  parameter bit CRLF_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         tx_busy,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic                         idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t          state, state_nx;
  logic            rx_valid_q;
  logic            push, pop, full, push_ok;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      head;
  logic            lf_pend;
  logic [TW-1:0]   tmo;

  // Rising edge of rx_valid marks a new byte; a held-high strobe counts once.
  assign push    = rx_valid & ~rx_valid_q;
  assign full    = (fifo_count == CW'(DEPTH));
  assign push_ok = push & (~full | pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // When full and popping, the write lands on the slot being read; the read sees the old byte.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (pop) state_nx = S_START;
      S_START:     state_nx = S_WAIT_ACK;
      S_WAIT_ACK:  if (tx_busy) state_nx = S_WAIT_DONE;
                   else if (tmo == TW'(ACK_TIMEOUT-1)) state_nx = S_START;
      S_WAIT_DONE: if (!tx_busy) state_nx = lf_pend ? S_START : S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = (state == S_IDLE) && (fifo_count != '0) && !tx_busy;
    tx_start = (state == S_START);
    idle     = (state == S_IDLE) && (fifo_count == '0);
  end

  // tx_data holds from the start pulse until the FSM returns to IDLE, so retries resend it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data <= 8'h00;
      lf_pend <= 1'b0;
      tmo     <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          tx_data <= head;
          lf_pend <= CRLF_EN && (head == 8'h0D);
        end
        S_START:    tmo <= '0;
        S_WAIT_ACK: if (tmo != '1) tmo <= tmo + 1'b1;
        S_WAIT_DONE: if (!tx_busy && lf_pend) begin
          tx_data <= 8'h0A;
          lf_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: a CRLF-enabled instance plus a plain-echo
// instance, with the uart transmitter's busy line modelled by hand.
module tb_uart_echo_responder;
  localparam int DEPTH = 16;
  localparam int TMO   = 16;

  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_valid0 = 1'b0, tx_busy = 1'b0, tx_busy0 = 1'b0;
  logic       tx_start, tx_start0, overflow, overflow0, idle, idle0;
  logic [7:0] tx_data, tx_data0;
  logic [4:0] fifo_count, fifo_count0;

  int tests = 0, fails = 0;
  int pulses = 0, pulses0 = 0;

  uart_echo_responder #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .CRLF_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
    .overflow(overflow), .idle(idle));

  uart_echo_responder #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .CRLF_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid0), .tx_busy(tx_busy0),
    .tx_start(tx_start0), .tx_data(tx_data0), .fifo_count(fifo_count0),
    .overflow(overflow0), .idle(idle0));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start)  pulses++;
    if (tx_start0) pulses0++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_start(input int budget, output bit got, output int cyc);
    int i = 0;
    got = 0; cyc = 0;
    while (!got && i < budget) begin
      @(negedge clk); i++;
      if (tx_start) begin got = 1; cyc = i; end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic busy_cycle();
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_data = 8'h55; rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", tx_start); end
    tests++; if (fifo_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b want 1", idle); end
    rx_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (fifo_count !== 5'd0 || idle !== 1'b1)
      begin fails++; $display("FAIL reset_release: count %0d idle %b want 0/1", fifo_count, idle); end
  endtask

  task automatic test_single_echo();
    int p0 = pulses;
    @(negedge clk); rx_data = 8'h41; rx_valid = 1'b1;
    @(negedge clk);
    tests++; if (fifo_count !== 5'd1) begin fails++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", tx_start); end
    @(negedge clk);
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_latency: got %b want 1", tx_start); end
    tests++; if (tx_data !== 8'h41) begin fails++; $display("FAIL single_data: got %h want 41", tx_data); end
    tx_busy = 1'b1;
    @(negedge clk);
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
    repeat (9) @(negedge clk);
    tx_busy = 1'b0;
    repeat (87) @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    tests++; if (idle !== 1'b1 || fifo_count !== 5'd0)
      begin fails++; $display("FAIL single_idle: idle %b count %0d want 1/0", idle, fifo_count); end
  endtask

  task automatic test_crlf();
    int p0 = pulses;
    bit got; int cyc; int i;
    push_byte(8'h0D);
    wait_start(20, got, cyc);
    tests++; if (!got || tx_data !== 8'h0D) begin fails++; $display("FAIL crlf_cr: got %b/%h want 1/0d", got, tx_data); end
    busy_cycle();
    wait_start(20, got, cyc);
    tests++; if (!got || tx_data !== 8'h0A) begin fails++; $display("FAIL crlf_lf: got %b/%h want 1/0a", got, tx_data); end
    busy_cycle();
    repeat (10) @(negedge clk);
    tests++; if (pulses - p0 !== 2 || idle !== 1'b1)
      begin fails++; $display("FAIL crlf_count: pulses %0d idle %b want 2/1", pulses - p0, idle); end
    // plain-echo instance: CR goes out alone
    p0 = pulses0; got = 0; i = 0;
    @(negedge clk); rx_data = 8'h0D; rx_valid0 = 1'b1;
    @(negedge clk); rx_valid0 = 1'b0;
    while (!got && i < 20) begin @(negedge clk); i++; if (tx_start0) got = 1; end
    tests++; if (!got || tx_data0 !== 8'h0D) begin fails++; $display("FAIL plain_cr: got %b/%h want 1/0d", got, tx_data0); end
    tx_busy0 = 1'b1; repeat (10) @(negedge clk); tx_busy0 = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (pulses0 - p0 !== 1 || idle0 !== 1'b1)
      begin fails++; $display("FAIL plain_count: pulses %0d idle %b want 1/1", pulses0 - p0, idle0); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    int p0 = pulses;
    bit got; int cyc;
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(i));
    tests++; if (fifo_count !== 5'd16) begin fails++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      exp.push_back(8'(i));
      if (i == 8'h0D) exp.push_back(8'h0A);
    end
    tx_busy = 1'b0;
    foreach (exp[k]) begin
      wait_start(40, got, cyc);
      tests++; if (!got || tx_data !== exp[k])
        begin fails++; $display("FAIL ovf_order[%0d]: got %b/%h want 1/%h", k, got, tx_data, exp[k]); end
      busy_cycle();
    end
    repeat (20) @(negedge clk);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    tests++; if (pulses - p0 !== 17 || idle !== 1'b1)
      begin fails++; $display("FAIL ovf_drain: pulses %0d idle %b want 17/1", pulses - p0, idle); end
  endtask

  task automatic test_timeout();
    bit got; int cyc;
    tx_busy = 1'b1;
    push_byte(8'h5A);
    push_byte(8'h33);
    tx_busy = 1'b0;
    wait_start(20, got, cyc);
    tests++; if (!got || tx_data !== 8'h5A) begin fails++; $display("FAIL tmo_first: got %b/%h want 1/5a", got, tx_data); end
    for (int r = 0; r < 2; r++) begin
      wait_start(40, got, cyc);
      tests++; if (!got || cyc !== TMO + 1)
        begin fails++; $display("FAIL tmo_period[%0d]: got %b/%0d want 1/%0d", r, got, cyc, TMO + 1); end
      tests++; if (tx_data !== 8'h5A) begin fails++; $display("FAIL tmo_data[%0d]: got %h want 5a", r, tx_data); end
    end
    tests++; if (fifo_count !== 5'd1) begin fails++; $display("FAIL tmo_count: got %0d want 1", fifo_count); end
    busy_cycle();
    wait_start(40, got, cyc);
    tests++; if (!got || tx_data !== 8'h33) begin fails++; $display("FAIL tmo_next: got %b/%h want 1/33", got, tx_data); end
    busy_cycle();
    repeat (5) @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL tmo_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    int p0;
    bit got; int cyc;
    tx_busy = 1'b1;
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    tests++; if (fifo_count !== 5'd3) begin fails++; $display("FAIL mid_count: got %0d want 3", fifo_count); end
    tx_busy = 1'b0;
    wait_start(20, got, cyc);
    tests++; if (!got || tx_data !== 8'h61) begin fails++; $display("FAIL mid_first: got %b/%h want 1/61", got, tx_data); end
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00)
      begin fails++; $display("FAIL mid_tx: start %b data %h want 0/00", tx_start, tx_data); end
    tests++; if (fifo_count !== 5'd0 || overflow !== 1'b0 || idle !== 1'b1)
      begin fails++; $display("FAIL mid_state: count %0d ovf %b idle %b want 0/0/1", fifo_count, overflow, idle); end
    tx_busy = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    p0 = pulses;
    repeat (60) @(negedge clk);
    tests++; if (pulses - p0 !== 0 || idle !== 1'b1)
      begin fails++; $display("FAIL mid_stale: pulses %0d idle %b want 0/1", pulses - p0, idle); end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_crlf();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
